// File: rtl/ifetch_queue_if.sv
// Fetch-side bus bundle: icache request/response pair plus the decoder-facing
// queue head handshake. The master modport is the fetch unit's view.
interface ifetch_queue_if;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_instr;
  logic        iq_valid;
  logic [31:0] iq_instr;
  logic [31:0] iq_pc;
  logic        iq_ready;

  modport master (
    output icache_req_valid, icache_req_addr,
    input  icache_resp_valid, icache_resp_instr,
    output iq_valid, iq_instr, iq_pc,
    input  iq_ready
  );

  modport slave (
    input  icache_req_valid, icache_req_addr,
    output icache_resp_valid, icache_resp_instr,
    input  iq_valid, iq_instr, iq_pc,
    output iq_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch unit with a show-ahead instruction queue feeding decode.
// One icache word request is outstanding at a time; fall-through prediction
// (pc+4), redirected by flush_in. A flush while a request is in flight moves
// to DRAIN so the stale response is swallowed instead of enqueued.
module ifetch_queue #(
  parameter int unsigned DEPTH_LOG = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic [31:0]           flush_pc_in,
  ifetch_queue_if.master        bus
);

  localparam int unsigned          DEPTH   = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0]   FULL    = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE = DEPTH_LOG'(1);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t               state, state_d;
  entry_t               mem [DEPTH];
  logic [DEPTH_LOG-1:0] head, tail;
  logic [DEPTH_LOG:0]   count, count_after_pop;
  logic [31:0]          pc, pc_d;
  logic                 req_valid, req_valid_d;
  logic [31:0]          req_addr, req_addr_d;
  logic                 not_empty, pop, push, flush;

  // rdy_in low freezes everything except response capture, so a flush only
  // acts while the pipeline is running.
  assign flush           = flush_in & rdy_in;
  assign not_empty       = (count != '0);
  assign pop             = not_empty & bus.iq_ready & rdy_in & ~flush_in;
  assign count_after_pop = count - {{DEPTH_LOG{1'b0}}, pop};

  assign bus.iq_valid         = not_empty;
  assign bus.iq_pc            = mem[head].pc;
  assign bus.iq_instr         = mem[head].instr;
  assign bus.icache_req_valid = req_valid;
  assign bus.icache_req_addr  = req_addr;

  // Next-state and next registered outputs; flush overrides every state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state;
    pc_d        = pc;
    req_valid_d = req_valid;
    req_addr_d  = req_addr;
    push        = 1'b0;
    if (flush) begin
      pc_d        = flush_pc_in;
      req_valid_d = 1'b0;
      // A request still in flight (WAIT, or DRAIN already waiting) must have
      // its response swallowed; a response landing now is simply dropped.
      state_d     = (state != IDLE && !bus.icache_resp_valid) ? DRAIN : IDLE;
    end else begin
      case (state)
        IDLE: begin
          // Space check uses post-pop occupancy; no push can happen in IDLE.
          if (rdy_in && count_after_pop < FULL) begin
            req_valid_d = 1'b1;
            req_addr_d  = pc;
            state_d     = WAIT;
          end
        end
        WAIT: begin
          // Captured even when rdy_in is low: the icache never retries.
          if (bus.icache_resp_valid) begin
            push        = 1'b1;
            pc_d        = pc + 32'd4;
            req_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        DRAIN: begin
          if (bus.icache_resp_valid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n_in) state <= IDLE;
    else           state <= state_d;
  end

  // Fetch PC, request registers and queue pointers/occupancy.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc        <= RESET_PC;
      req_valid <= 1'b0;
      req_addr  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      pc        <= pc_d;
      req_valid <= req_valid_d;
      req_addr  <= req_addr_d;
      if (flush) begin
        head  <= tail;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_ONE;
        if (pop)  head <= head + PTR_ONE;
        count <= count_after_pop + {{DEPTH_LOG{1'b0}}, push};
      end
    end
  end

  // Queue storage write port.
  always_ff @(posedge clk_in) begin
    // NOTE: storage is not reset; count gates iq_valid, so stale contents are never consumed.
    if (push) mem[tail] <= '{pc: pc, instr: bus.icache_resp_instr};
  end

endmodule
